arb_param_hold: RTL and testbench
=================================

Name: arb_param_hold

Overview:
- Parametrised N-requester arbiter with registered one-hot grant.
- Run-time selectable fixed-priority or round-robin mode.
- Optional grant hold (bus lock) while the owner keeps requesting, bounded by a maximum hold count.
- Replaces the hard-coded 4-input fixed arbiter in shared-resource paths (bus/memory port muxing).

Parameters:
- N, 4, number of requesters; legal range 2..32.
- MAX_HOLD, 4, maximum consecutive cycles one owner may keep the grant; 0 = no hold, re-arbitrate every cycle.
- IDX_W, $clog2(N), width of gnt_idx; derived, not overridden.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode_rr  input  1  0 = fixed priority (highest index wins), 1 = round-robin; sampled every cycle.
- req  input  N  request vector, bit i = requester i.
- gnt  output  N  registered one-hot grant, all-zero when idle.
- gnt_valid  output  1  high when gnt is non-zero.
- gnt_idx  output  IDX_W  binary index of the granted requester; holds its last value when gnt_valid = 0.

Behaviour:
- Reset: gnt = 0, gnt_valid = 0, gnt_idx = 0, rr pointer ptr = 0, hold_cnt = 0.
- Reset is async assert and takes effect mid-grant immediately, with no completion of the current hold.
- Latency: req sampled at posedge k; the resulting gnt is visible after posedge k, with no combinational req->gnt path.
- Hold condition: current owner o has req[o] = 1 and hold_cnt < MAX_HOLD-1 (MAX_HOLD > 0).
  - Next gnt = same owner; hold_cnt++.
- Otherwise a new arbitration is performed:
  - Candidate set = req. If the owner's hold expired (hold_cnt = MAX_HOLD-1 and req[o] = 1) and any other req bit is set, exclude o for this arbitration.
  - If only o requests, o re-wins.
  - Fixed mode: highest set index wins.
  - RR mode: search descending from ptr-1, wrapping 0 -> N-1, and ending at ptr (ptr itself checked last). After reset, ptr = 0, so the first RR search order equals fixed priority.
  - Winner w: gnt = onehot(w), gnt_idx = w, gnt_valid = 1, hold_cnt = 0, ptr = w (ptr updates in both modes).
  - Empty candidate set: gnt = 0, gnt_valid = 0, hold_cnt = 0; ptr and gnt_idx unchanged.
- Owner drops req: the grant is released at the next edge, with no one-cycle dead gap if other requests are pending.
- mode_rr change mid-hold: the hold continues; the new mode applies at the next arbitration.
- Invariant: gnt is always one-hot or zero, and a grant is only ever given to a requester whose req was high at the sampling edge.

Optional Feature:
- Macro: ARB_REQ_MASK_EN.
- Defined: adds input port req_mask [N-1:0].
  - Effective request = req & ~req_mask.
  - A masked owner loses the grant at the next edge even mid-hold; masked requesters are never granted.
- Undefined: port absent, all requests eligible; RTL otherwise identical.

Test Plan:
All scenarios use N = 4.
1. Reset and single requests: rst_n = 0 mid-grant -> gnt = 0000 within the same cycle. Then MAX_HOLD = 0, fixed mode: req = 1000, 1010, 0010, 0110, 1111 on successive cycles -> gnt one cycle later = 1000, 1000, 0010, 0100, 1000; gnt_valid = 1 each time.
2. RR fairness: MAX_HOLD = 0, mode_rr = 1, req held at 1111 for 8 cycles -> gnt sequence 1000, 0100, 0010, 0001, 1000, 0100, 0010, 0001; gnt_idx = 3, 2, 1, 0, ...
3. Hold and expiry: MAX_HOLD = 4, fixed mode, req = 0011 constant -> gnt = 0010 for 4 cycles, then 0001 for 4 cycles (req[1] excluded at expiry), then 0010 again.
4. Sole-requester hold expiry: MAX_HOLD = 2, req = 0100 for 6 cycles -> gnt = 0100 continuously with no gap. Then req = 0000 -> gnt = 0000, gnt_valid = 0, gnt_idx stays 2.
5. Early release: MAX_HOLD = 4, mode_rr = 1, owner 3 drops req after 1 cycle while req = 0101 -> next gnt = 0100 (search from ptr-1 = 2). Then mode_rr toggles mid-hold -> grant unchanged until the next arbitration.
6. (ARB_REQ_MASK_EN) req = 1111, req_mask = 1000 -> gnt = 0100. Setting req_mask = 0100 mid-hold -> gnt = 1000 at the next edge.

Source files
------------

// File: rtl/arb_param_hold.sv
// N-requester arbiter with a registered one-hot grant, fixed-priority or round-robin mode and bounded grant hold.
// Optional macro ARB_REQ_MASK_EN adds a req_mask input that removes requesters from arbitration.
module arb_param_hold #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 4,
    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_rr,
    input  logic [N-1:0]     req,
`ifdef ARB_REQ_MASK_EN
    input  logic [N-1:0]     req_mask,
`endif
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    logic [N-1:0]     gnt_q, gnt_d;
    logic             vld_q, vld_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic [N-1:0]     eff_req;
    logic [N-1:0]     owner_oh;
    logic [N-1:0]     others;
    logic [N-1:0]     cand;
    logic             owner_req;
    logic             hold;
    logic             expired;
    logic [IDX_W-1:0] fix_win;
    logic [IDX_W-1:0] rr_win;
    logic             rr_found;
    logic [IDX_W-1:0] rr_j;
    logic [IDX_W-1:0] win;

    // Candidate set: an owner whose hold just ran out steps aside if anyone else is waiting.
    always_comb begin
`ifdef ARB_REQ_MASK_EN
        eff_req = req & ~req_mask;
`else
        eff_req = req;
`endif
        owner_oh        = '0;
        owner_oh[idx_q] = 1'b1;
        owner_req       = vld_q && eff_req[idx_q];
        hold            = (MAX_HOLD > 0) && owner_req && (hold_cnt_q < HOLD_LAST);
        expired         = (MAX_HOLD > 0) && owner_req && (hold_cnt_q == HOLD_LAST);
        others          = eff_req & ~owner_oh;
        cand            = (expired && (|others)) ? others : eff_req;
    end

    always_comb begin
        fix_win = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) fix_win = IDX_W'(i);
        end
    end

    // Round-robin search walks downward from ptr-1, wrapping, with ptr itself examined last.
    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        rr_j     = '0;
        for (int k = 1; k <= N; k++) begin
            if (int'(ptr_q) >= k) rr_j = IDX_W'(int'(ptr_q) - k);
            else                  rr_j = IDX_W'(int'(ptr_q) + N - k);
            if (!rr_found && cand[rr_j]) begin
                rr_found = 1'b1;
                rr_win   = rr_j;
            end
        end
    end

    always_comb begin
        win        = mode_rr ? rr_win : fix_win;
        gnt_d      = gnt_q;
        vld_d      = vld_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        if (hold) begin
            vld_d      = 1'b1;
            hold_cnt_d = hold_cnt_q + HC_W'(1);
        end else if (|cand) begin
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            vld_d      = 1'b1;
            idx_d      = win;
            ptr_d      = win;
            hold_cnt_d = '0;
        end else begin
            gnt_d      = '0;
            vld_d      = 1'b0;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q      <= '0;
            vld_q      <= 1'b0;
            idx_q      <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            gnt_q      <= gnt_d;
            vld_q      <= vld_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = vld_q;
    assign gnt_idx   = idx_q;

endmodule

// File: tb/tb_arb_param_hold.sv
// Directed, table-driven bench for arb_param_hold (N = 4) with MAX_HOLD = 0, 2 and 4 instances side by side.
`timescale 1ns/1ps
module tb_arb_param_hold;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_rr = 1'b0;
    logic [3:0] req = 4'b0000;
`ifdef ARB_REQ_MASK_EN
    logic [3:0] req_mask = 4'b0000;
`endif

    logic [3:0] gnt0, gnt2, gnt4;
    logic       vld0, vld2, vld4;
    logic [1:0] idx0, idx2, idx4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arb_param_hold #(.N(4), .MAX_HOLD(0)) u_h0 (
        .clk(clk), .rst_n(rst_n), .mode_rr(mode_rr), .req(req),
`ifdef ARB_REQ_MASK_EN
        .req_mask(req_mask),
`endif
        .gnt(gnt0), .gnt_valid(vld0), .gnt_idx(idx0));

    arb_param_hold #(.N(4), .MAX_HOLD(2)) u_h2 (
        .clk(clk), .rst_n(rst_n), .mode_rr(mode_rr), .req(req),
`ifdef ARB_REQ_MASK_EN
        .req_mask(req_mask),
`endif
        .gnt(gnt2), .gnt_valid(vld2), .gnt_idx(idx2));

    arb_param_hold #(.N(4), .MAX_HOLD(4)) u_h4 (
        .clk(clk), .rst_n(rst_n), .mode_rr(mode_rr), .req(req),
`ifdef ARB_REQ_MASK_EN
        .req_mask(req_mask),
`endif
        .gnt(gnt4), .gnt_valid(vld4), .gnt_idx(idx4));

    typedef struct {
        int         sel;    // 0: MAX_HOLD=0, 1: MAX_HOLD=2, 2: MAX_HOLD=4
        logic       rst;    // pulse reset before this row
        logic       mode;
        logic [3:0] req;
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] idx;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input int sel, input string name,
                             input logic [3:0] eg, input logic ev, input logic [1:0] ei);
        logic [3:0] g;
        logic       v;
        logic [1:0] x;
        case (sel)
            0:       begin g = gnt0; v = vld0; x = idx0; end
            1:       begin g = gnt2; v = vld2; x = idx2; end
            default: begin g = gnt4; v = vld4; x = idx4; end
        endcase
        check({name, "_gnt"}, 32'(g), 32'(eg));
        check({name, "_vld"}, 32'(v), 32'(ev));
        check({name, "_idx"}, 32'(x), 32'(ei));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        req     = 4'b0000;
        mode_rr = 1'b0;
`ifdef ARB_REQ_MASK_EN
        req_mask = 4'b0000;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply(input int sel, input logic m, input logic [3:0] r,
                         input logic [3:0] eg, input logic ev, input logic [1:0] ei,
                         input string name);
        @(negedge clk);
        mode_rr = m;
        req     = r;
        @(posedge clk);
        #1;
        check_out(sel, name, eg, ev, ei);
    endtask

    task automatic add(input int s, input logic rs, input logic m, input logic [3:0] r,
                       input logic [3:0] g, input logic v, input logic [1:0] x);
        vec_t e;
        e.sel = s; e.rst = rs; e.mode = m; e.req = r; e.gnt = g; e.vld = v; e.idx = x;
        tv.push_back(e);
    endtask

    initial begin
        // Fixed priority, no hold
        add(0, 1, 0, 4'b1000, 4'b1000, 1, 3);
        add(0, 0, 0, 4'b1010, 4'b1000, 1, 3);
        add(0, 0, 0, 4'b0010, 4'b0010, 1, 1);
        add(0, 0, 0, 4'b0110, 4'b0100, 1, 2);
        add(0, 0, 0, 4'b1111, 4'b1000, 1, 3);
        // Round-robin fairness from a fresh pointer
        add(0, 1, 1, 4'b1111, 4'b1000, 1, 3);
        add(0, 0, 1, 4'b1111, 4'b0100, 1, 2);
        add(0, 0, 1, 4'b1111, 4'b0010, 1, 1);
        add(0, 0, 1, 4'b1111, 4'b0001, 1, 0);
        add(0, 0, 1, 4'b1111, 4'b1000, 1, 3);
        add(0, 0, 1, 4'b1111, 4'b0100, 1, 2);
        add(0, 0, 1, 4'b1111, 4'b0010, 1, 1);
        add(0, 0, 1, 4'b1111, 4'b0001, 1, 0);
        // Hold of 4 then the expired owner is excluded
        add(2, 1, 0, 4'b0011, 4'b0010, 1, 1);
        add(2, 0, 0, 4'b0011, 4'b0010, 1, 1);
        add(2, 0, 0, 4'b0011, 4'b0010, 1, 1);
        add(2, 0, 0, 4'b0011, 4'b0010, 1, 1);
        add(2, 0, 0, 4'b0011, 4'b0001, 1, 0);
        add(2, 0, 0, 4'b0011, 4'b0001, 1, 0);
        add(2, 0, 0, 4'b0011, 4'b0001, 1, 0);
        add(2, 0, 0, 4'b0011, 4'b0001, 1, 0);
        add(2, 0, 0, 4'b0011, 4'b0010, 1, 1);
        // Sole requester re-wins past expiry, then idle keeps the index
        add(1, 1, 0, 4'b0100, 4'b0100, 1, 2);
        add(1, 0, 0, 4'b0100, 4'b0100, 1, 2);
        add(1, 0, 0, 4'b0100, 4'b0100, 1, 2);
        add(1, 0, 0, 4'b0100, 4'b0100, 1, 2);
        add(1, 0, 0, 4'b0100, 4'b0100, 1, 2);
        add(1, 0, 0, 4'b0100, 4'b0100, 1, 2);
        add(1, 0, 0, 4'b0000, 4'b0000, 0, 2);
        // Early release in RR, mode flip mid-hold, fixed mode at expiry, release with no gap
        add(2, 1, 1, 4'b1000, 4'b1000, 1, 3);
        add(2, 0, 1, 4'b0101, 4'b0100, 1, 2);
        add(2, 0, 0, 4'b1101, 4'b0100, 1, 2);
        add(2, 0, 0, 4'b1101, 4'b0100, 1, 2);
        add(2, 0, 0, 4'b1101, 4'b0100, 1, 2);
        add(2, 0, 0, 4'b1101, 4'b1000, 1, 3);
        add(2, 0, 0, 4'b0001, 4'b0001, 1, 0);

        // Reset state
        #12;
        check_out(0, "rst_h0", 4'b0000, 1'b0, 2'd0);
        check_out(2, "rst_h4", 4'b0000, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a grant
        apply(2, 1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1, "pre_rst");
        #3;
        rst_n = 1'b0;
        #1;
        check_out(2, "async_rst", 4'b0000, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        check_out(2, "rst_held", 4'b0000, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0000;

        foreach (tv[i]) begin
            if (tv[i].rst) do_reset();
            apply(tv[i].sel, tv[i].mode, tv[i].req, tv[i].gnt, tv[i].vld, tv[i].idx,
                  $sformatf("v%0d", i));
        end

`ifdef ARB_REQ_MASK_EN
        do_reset();
        req_mask = 4'b1000;
        apply(2, 1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, "mask_hi");
        req_mask = 4'b0100;
        apply(2, 1'b0, 4'b1111, 4'b1000, 1'b1, 2'd3, "mask_owner");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
